// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave (all four modes) with RX/TX FIFOs, frame strobes and
// overflow/underflow pulses, clocked entirely in the system clock domain.
// Optional build macro SPI_SLAVE_WORDCNT_EN adds the frame_words output.
module spi_slave_fifo #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       RX_DEPTH    = 8,
  parameter int unsigned       TX_DEPTH    = 8,
  parameter int unsigned       SPI_MODE    = 0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = '1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        SPI_clock,
  input  logic                        SPI_cs_n,
  input  logic                        SPI_mosi,
  output logic                        SPI_miso,
  output logic [DATA_W-1:0]           RX_data,
  output logic                        RX_valid,
  input  logic                        RX_ready,
  output logic [$clog2(RX_DEPTH):0]   RX_level,
  input  logic [DATA_W-1:0]           TX_data,
  input  logic                        TX_valid,
  output logic                        TX_ready,
  output logic                        frame_start,
  output logic                        frame_end,
  output logic                        RX_overflow,
  output logic                        TX_underflow
`ifdef SPI_SLAVE_WORDCNT_EN
  ,
  output logic [15:0]                 frame_words
`endif
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic        CPOL  = SPI_MODE[1];
  localparam logic        CPHA  = SPI_MODE[0];
  localparam logic        SAMPLE_RISE = (CPOL == CPHA);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchroniser chains and previous-sample flops
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  // SPI engine state
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_word_q, rx_word_d;
  logic              rx_push_q, rx_push_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
  logic              tx_loaded_q, tx_loaded_d;
  logic              tx_pend_q, tx_pend_d;
  logic              tx_pend_pop_q, tx_pend_pop_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic              tx_uf_q, tx_uf_d;

  // FIFO state
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [RX_AW:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_level_q, rx_level_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_head_q, rx_head_d;
  logic [TX_AW:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic              tx_ready_q, tx_ready_d;

  // Decoded events
  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic              sample_ev, shift_ev, word_done;
  logic              tx_empty, tx_pop, tx_push;
  logic [DATA_W-1:0] tx_src;
  logic              rx_full, rx_pop, rx_wr_en;

  // Pin synchronisers; CS idles deasserted and SCLK idles at CPOL
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_clock};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  // Edge decode; SCLK edges only count inside a running frame
  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    cs_s      = cs_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    cs_fall   = cs_prev_q & ~cs_s;
    cs_rise   = ~cs_prev_q & cs_s;
    sample_ev = ~cs_s & ~cs_fall & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    shift_ev  = ~cs_s & ~cs_fall & (SAMPLE_RISE ? sclk_fall : sclk_rise);
    word_done = sample_ev & (bit_cnt_q == LAST_BIT);
    tx_empty  = (tx_wr_q == tx_rd_q);
    tx_src    = tx_empty ? IDLE_WORD : tx_mem[tx_rd_q[TX_AW-1:0]];
  end

  // SPI shift engine: RX assembly, TX loading and MISO drive
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_word_d     = rx_word_q;
    rx_push_d     = 1'b0;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    tx_loaded_d   = tx_loaded_q;
    tx_pend_d     = tx_pend_q;
    tx_pend_pop_d = tx_pend_pop_q;
    frame_start_d = cs_fall;
    frame_end_d   = cs_rise;
    tx_uf_d       = 1'b0;
    tx_pop        = 1'b0;
    if (cs_s) begin
      bit_cnt_d   = '0;
      rx_shift_d  = '0;
      miso_d      = 1'b0;
      tx_loaded_d = 1'b0;
      tx_pend_d   = 1'b0;
    end else if (cs_fall) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_pop     = ~tx_empty;
      tx_uf_d    = tx_empty;
      if (CPHA) begin
        tx_shift_d  = tx_src;
        tx_loaded_d = 1'b1;
        miso_d      = 1'b0;
      end else begin
        tx_shift_d = {tx_src[DATA_W-2:0], 1'b0};
        miso_d     = tx_src[DATA_W-1];
      end
    end else begin
      if (sample_ev) begin
        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
        // CPHA=0 word loaded at completion is only consumed once the word really starts
        if (!CPHA && tx_pend_q && (bit_cnt_q == '0)) begin
          tx_pop    = tx_pend_pop_q;
          tx_uf_d   = ~tx_pend_pop_q;
          tx_pend_d = 1'b0;
        end
        if (word_done) begin
          bit_cnt_d = '0;
          rx_word_d = rx_shift_d;
          rx_push_d = 1'b1;
          if (!CPHA) begin
            tx_shift_d    = {tx_src[DATA_W-2:0], 1'b0};
            miso_d        = tx_src[DATA_W-1];
            tx_pend_d     = 1'b1;
            tx_pend_pop_d = ~tx_empty;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      if (shift_ev) begin
        if (CPHA && (bit_cnt_q == '0) && !tx_loaded_q) begin
          tx_pop     = ~tx_empty;
          tx_uf_d    = tx_empty;
          miso_d     = tx_src[DATA_W-1];
          tx_shift_d = {tx_src[DATA_W-2:0], 1'b0};
        end else if (CPHA || (bit_cnt_q != '0)) begin
          miso_d     = tx_shift_q[DATA_W-1];
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
        tx_loaded_d = 1'b0;
      end
    end
  end

  // FIFO pointer arithmetic and registered status
  always_comb begin
    rx_pop     = RX_ready & rx_valid_q;
    rx_full    = (rx_level_q == (RX_AW+1)'(RX_DEPTH));
    rx_wr_en   = rx_push_q & (~rx_full | rx_pop);
    rx_ovf_d   = rx_push_q & rx_full & ~rx_pop;
    rx_wr_d    = rx_wr_q + (RX_AW+1)'(rx_wr_en);
    rx_rd_d    = rx_rd_q + (RX_AW+1)'(rx_pop);
    rx_level_d = rx_wr_d - rx_rd_d;
    rx_valid_d = (rx_level_d != '0);
    // Bypass the word being written when it becomes the new head
    rx_head_d  = (rx_wr_en && (rx_wr_q[RX_AW-1:0] == rx_rd_d[RX_AW-1:0])) ?
                 rx_word_q : rx_mem[rx_rd_d[RX_AW-1:0]];
    tx_push    = TX_valid & tx_ready_q;
    tx_wr_d    = tx_wr_q + (TX_AW+1)'(tx_push);
    tx_rd_d    = tx_rd_q + (TX_AW+1)'(tx_pop);
    tx_ready_d = ((tx_wr_d - tx_rd_d) != (TX_AW+1)'(TX_DEPTH));
  end

  // FIFO storage, not reset
  always_ff @(posedge clock) begin
    if (rx_wr_en) rx_mem[rx_wr_q[RX_AW-1:0]] <= rx_word_q;
    if (tx_push)  tx_mem[tx_wr_q[TX_AW-1:0]] <= TX_data;
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_word_q     <= '0;
      rx_push_q     <= 1'b0;
      tx_shift_q    <= '0;
      miso_q        <= 1'b0;
      tx_loaded_q   <= 1'b0;
      tx_pend_q     <= 1'b0;
      tx_pend_pop_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      rx_ovf_q      <= 1'b0;
      tx_uf_q       <= 1'b0;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      rx_level_q    <= '0;
      rx_valid_q    <= 1'b0;
      rx_head_q     <= '0;
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      tx_ready_q    <= 1'b1;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_word_q     <= rx_word_d;
      rx_push_q     <= rx_push_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      tx_loaded_q   <= tx_loaded_d;
      tx_pend_q     <= tx_pend_d;
      tx_pend_pop_q <= tx_pend_pop_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      rx_ovf_q      <= rx_ovf_d;
      tx_uf_q       <= tx_uf_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      rx_level_q    <= rx_level_d;
      rx_valid_q    <= rx_valid_d;
      rx_head_q     <= rx_head_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      tx_ready_q    <= tx_ready_d;
    end
  end

`ifdef SPI_SLAVE_WORDCNT_EN
  logic [15:0] words_q;

  // Saturating per-frame word counter, held after the frame ends
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      words_q <= '0;
    end else if (cs_fall) begin
      words_q <= '0;
    end else if (word_done && (words_q != 16'hFFFF)) begin
      words_q <= words_q + 16'd1;
    end
  end

  assign frame_words = words_q;
`endif

  assign SPI_miso     = miso_q;
  assign RX_data      = rx_head_q;
  assign RX_valid     = rx_valid_q;
  assign RX_level     = rx_level_q;
  assign TX_ready     = tx_ready_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign RX_overflow  = rx_ovf_q;
  assign TX_underflow = tx_uf_q;

endmodule
